// File: rtl/pll_lock_supervisor_if.sv
// PLL-side and status signals of the lock supervisor, grouped for port connection.
// master = supervisor side, slave = PLL / status-register side.
interface pll_lock_supervisor_if #(
  parameter int CNT_W = 8
);
  logic             locked;
  logic             pll_rst;
  logic             rst_out_n;
  logic             ready;
  logic [2:0]       state;
  logic [CNT_W-1:0] relock_cnt;
  logic [CNT_W-1:0] timeout_cnt;

  modport master (
    input  locked,
    output pll_rst, rst_out_n, ready, state, relock_cnt, timeout_cnt
  );

  modport slave (
    output locked,
    input  pll_rst, rst_out_n, ready, state, relock_cnt, timeout_cnt
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Qualifies the asynchronous PLL lock flag, releases the downstream reset after a stable
// lock, forces a PLL reset on lock timeout and counts lock-loss / timeout events.
module pll_lock_supervisor #(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 2000,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int PLLRST_CYCLES  = 64,
  parameter int CNT_W          = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pll_lock_supervisor_if.master bus
);

  localparam int MAX_A  = (STABLE_CYCLES > TIMEOUT_CYCLES) ? STABLE_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_C  = (MAX_A > PLLRST_CYCLES) ? MAX_A : PLLRST_CYCLES;
  localparam int CNT_B  = $clog2(MAX_C) + 1;

  localparam logic [CNT_B-1:0] LOAD_PLLRST  = CNT_B'(PLLRST_CYCLES - 1);
  localparam logic [CNT_B-1:0] LOAD_TIMEOUT = CNT_B'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_B-1:0] LOAD_STABLE  = CNT_B'(STABLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_PLLRST = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3
  } state_t;

  state_t                 state_reg, state_next;
  logic [CNT_B-1:0]       cnt_reg, cnt_next, cnt_eff;
  logic                   boot_reg;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   lk;
  logic                   pll_rst_reg, ready_reg, rst_out_reg;
  logic [CNT_W-1:0]       relock_reg, timeout_reg;
  logic                   relock_inc, timeout_inc;

  // Only place the raw lock flag is sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.locked};
    end
  end

  assign lk = sync_reg[SYNC_STAGES-1];

  // Reset leaves cnt at 0; the first cycle after reset behaves as a fresh PLLRST entry so the
  // boot pulse is the full width.
  assign cnt_eff = boot_reg ? LOAD_PLLRST : cnt_reg;

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    relock_inc  = 1'b0;
    timeout_inc = 1'b0;
    case (state_reg)
      S_PLLRST: begin
        if (cnt_eff == '0) begin
          state_next = S_WAIT;
          cnt_next   = LOAD_TIMEOUT;
        end else begin
          cnt_next = cnt_eff - CNT_B'(1);
        end
      end
      S_WAIT: begin
        if (lk) begin
          state_next = S_STABLE;
          cnt_next   = LOAD_STABLE;
        end else if (cnt_reg == '0) begin
          state_next  = S_PLLRST;
          cnt_next    = LOAD_PLLRST;
          timeout_inc = 1'b1;
        end else begin
          cnt_next = cnt_reg - CNT_B'(1);
        end
      end
      S_STABLE: begin
        if (!lk) begin
          state_next = S_WAIT;
          cnt_next   = LOAD_TIMEOUT;
        end else if (cnt_reg == '0) begin
          state_next = S_RUN;
        end else begin
          cnt_next = cnt_reg - CNT_B'(1);
        end
      end
      S_RUN: begin
        if (!lk) begin
          state_next = S_WAIT;
          cnt_next   = LOAD_TIMEOUT;
          relock_inc = 1'b1;
        end
      end
      default: begin
        state_next = S_PLLRST;
        cnt_next   = LOAD_PLLRST;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_PLLRST;
      cnt_reg     <= '0;
      boot_reg    <= 1'b1;
      pll_rst_reg <= 1'b1;
      ready_reg   <= 1'b0;
      rst_out_reg <= 1'b0;
      relock_reg  <= '0;
      timeout_reg <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      boot_reg    <= 1'b0;
      // Outputs decode the next state so they change on the same edge as the state.
      pll_rst_reg <= (state_next == S_PLLRST);
      ready_reg   <= (state_next == S_RUN);
      rst_out_reg <= (state_next == S_RUN);
      if (relock_inc && (relock_reg != '1)) begin
        relock_reg <= relock_reg + CNT_W'(1);
      end
      if (timeout_inc && (timeout_reg != '1)) begin
        timeout_reg <= timeout_reg + CNT_W'(1);
      end
    end
  end

  assign bus.pll_rst     = pll_rst_reg;
  assign bus.ready       = ready_reg;
  assign bus.rst_out_n   = rst_out_reg;
  assign bus.state       = state_reg;
  assign bus.relock_cnt  = relock_reg;
  assign bus.timeout_cnt = timeout_reg;

endmodule
